mprj_bram_prefetch_ctrl: RTL and testbench
==========================================

Name: mprj_bram_prefetch_ctrl

Overview:
- Wishbone classic slave serving the user-project BRAM window (mprjram, 0x3800_0000) that firmware-resident kernels such as matmul() execute from.
- Emulates slow memory with a programmable access delay; hides the delay for sequential instruction fetch with a one-word read-ahead buffer.
- Exports hit/miss counters so the latency of the 0xAB40→0xAB51 checkbits window can be attributed to memory stalls.

Parameters:
- ADDR_BASE, 32'h3800_0000, window base
- ADDR_MASK, 32'hFF00_0000, bits compared for decode
- DEPTH_WORDS, 1024, BRAM depth in 32-bit words (power of 2)
- DELAY, 10, wait cycles per BRAM access (≥1)

Ports:
- wb_clk_i  in  1  the single clock
- wb_rstn_i  in  1  reset; asynchronous, active-low
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lane enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid while ack high
- busy_o  out  1  high in any state other than IDLE
- hit_cnt_o  out  16  read-ahead hits, saturating
- miss_cnt_o  out  16  read misses, saturating

Behaviour:
- Reset (async assert, sync release): ack=0, dat_o=0, busy=0, counters=0, buffer invalid, state IDLE. BRAM contents are not cleared.
- Decode: request = cyc & stb & ((adr & ADDR_MASK) == ADDR_BASE). Undecoded requests are never acked.
- Word index = adr[log2(DEPTH_WORDS)+1:2]; higher in-window bits alias.
- States: IDLE, WAIT, ACK, PREF.
- Read hit: request sampled in IDLE at edge T0, buffer valid, address equals buffer address.
  - ack=1 and dat_o=buffer data at T0+1.
  - hit_cnt increments.
  - Buffer invalidates; prefetch of adr+4 starts at T0+1 (state PREF).
- Read miss: request sampled in IDLE or PREF (aborting PREF) at T0; state WAIT with counter=DELAY.
  - Counter decrements each cycle; BRAM read is issued when counter reaches 0.
  - ack=1 with data at T0+DELAY+1.
  - miss_cnt increments at ack.
  - Prefetch of adr+4 starts the cycle after ack.
- Write: sampled at T0, same WAIT path.
  - Byte-masked write by sel at counter 0; ack at T0+DELAY+1.
  - A pending prefetch aborts.
  - If a valid buffer address equals the write address, the buffer invalidates.
  - State returns to IDLE after ack; no prefetch.
- PREF: background read of buffer address, DELAY+1 cycles; on completion buffer is valid and state is IDLE.
  - Request arriving during PREF with address == prefetch address (read): held; ack on the cycle after prefetch completes; counts as hit.
  - Any other request arriving during PREF: prefetch aborts, request handled as miss/write from that edge.
- Prefetch address at the top of the window wraps within DEPTH_WORDS (index+1 mod DEPTH_WORDS).
- ack is exactly one cycle. The request is ignored in the ack cycle; the master must drop stb. The earliest back-to-back request is sampled at the edge after ack falls.
- cyc dropped mid-WAIT: the access completes internally (a write still commits); no ack is issued if cyc/stb are low at the ack edge.
- Reset mid-operation: ack drops immediately; a pending write does not commit unless its BRAM cycle already occurred.
- Counters saturate at 16'hFFFF.

Decomposition:
- Shared package mprj_mem_pkg:
  - state enum
  - ADDR_BASE/ADDR_MASK defaults
  - WB_SEL_W=4, CNT_W=16
- Sub-module bram_sp_1r1w: single-port synchronous BRAM, 32-bit, byte write enables, 1-cycle read latency, parameter DEPTH_WORDS.
- The controller holds the FSM, delay counter, buffer and counters.

Test Plan:
- Reset: assert wb_rstn_i mid-WAIT → ack/busy drop same cycle; counters 0; state IDLE.
- Write 0x3800_0010 = 0xDEAD_BEEF sel=4'hF, DELAY=10 → ack at T0+11. Read back → miss, ack at T0+11, dat 0xDEAD_BEEF, miss_cnt=1.
- Sequential reads 0x3800_0000..0x3800_000C, request issued 12 cycles after each ack → first miss (ack T0+11), next three hits each acked T0+1; hit_cnt=3, miss_cnt=1.
- Read 0x3800_0004 issued 3 cycles after the ack of 0x3800_0000 (prefetch in flight) → held, acked the cycle after prefetch completes; hit_cnt=1.
- Write 0x3800_0004 = 0x1234_5678 with 0x3800_0004 buffered, then read 0x3800_0004 → buffer invalidated; read is a miss returning 0x1234_5678.
- Read 0x3900_0000 → no ack for 50 cycles; counters unchanged. Read of the last word (index 1023) → prefetch targets index 0 (0x3800_0000).

Source files
------------

// File: rtl/mprj_mem_pkg.sv
// Shared types and defaults for the mprjram window controller.
// States, decode defaults and the saturating counter helper.
package mprj_mem_pkg;

  localparam logic [31:0] ADDR_BASE_DEF = 32'h3800_0000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'hFF00_0000;
  localparam int WB_SEL_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_PREF
  } pf_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bram_sp_1r1w.sv
// Single-port synchronous BRAM, 32-bit words, byte write enables.
// Read data appears one cycle after the read and holds until the next read.
module bram_sp_1r1w
  import mprj_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [WB_SEL_W-1:0]            be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WB_SEL_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mprj_bram_prefetch_ctrl.sv
// Wishbone slave for the mprjram window: delayed BRAM access with a
// one-word sequential read-ahead buffer and hit/miss counters.
module mprj_bram_prefetch_ctrl
  import mprj_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter logic [31:0] ADDR_MASK   = ADDR_MASK_DEF,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          DELAY       = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [WB_SEL_W-1:0] wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int DW = $clog2(DELAY + 1);
  localparam logic [DW-1:0] DLY = DW'(DELAY);
  localparam logic [DW-1:0] ONE = DW'(1);

  pf_state_e           state_q, state_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [AW-1:0]       buf_idx_q, buf_idx_d;
  logic                buf_vld_q, buf_vld_d;
  logic [31:0]         buf_dat_q, buf_dat_d;
  logic                ack_q, ack_d;
  logic                ack_buf_q, ack_buf_d;
  logic [CNT_W-1:0]    hit_q, miss_q;
  logic                hit_inc, miss_inc;
  logic                mem_en, mem_we, start;
  logic [AW-1:0]       mem_addr;
  logic [31:0]         rdata;

  logic          req, take, idx_eq;
  logic [AW-1:0] req_idx;

  assign req     = wbs_cyc_i & wbs_stb_i &
                   ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  assign take    = req & ~ack_q;
  assign req_idx = wbs_adr_i[AW+1:2];
  assign idx_eq  = req_idx == buf_idx_q;

  assign mem_addr = (state_q == S_PREF) ? buf_idx_q : idx_q;

  bram_sp_1r1w #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .clk  (wb_clk_i),
    .en   (mem_en),
    .we   (mem_we),
    .be   (sel_q),
    .addr (mem_addr),
    .wdata(wdat_q),
    .rdata(rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    buf_idx_d = buf_idx_q;
    buf_vld_d = buf_vld_q;
    buf_dat_d = buf_dat_q;
    ack_d     = 1'b0;
    ack_buf_d = ack_buf_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take && !wbs_we_i && buf_vld_q && idx_eq) begin
          ack_d     = 1'b1;
          ack_buf_d = 1'b1;
          hit_inc   = 1'b1;
          buf_vld_d = 1'b0;
          buf_idx_d = buf_idx_q + 1'b1;
          cnt_d     = DLY;
          state_d   = S_PREF;
        end else if (take) begin
          start = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ONE) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          ack_d     = req;
          ack_buf_d = 1'b0;
          miss_inc  = req & ~we_q;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          buf_idx_d = idx_q + 1'b1;
          buf_vld_d = 1'b0;
          cnt_d     = DLY;
          state_d   = S_PREF;
        end
      end
      S_PREF: begin
        // A read of the address being fetched waits for it.
        if (take && (wbs_we_i || !idx_eq)) begin
          start = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          mem_en = cnt_q == ONE;
          if (cnt_q == '0) begin
            buf_dat_d = rdata;
            buf_vld_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_WAIT;
      cnt_d   = DLY;
      idx_d   = req_idx;
      we_d    = wbs_we_i;
      sel_d   = wbs_sel_i;
      wdat_d  = wbs_dat_i;
      if (wbs_we_i && buf_vld_q && idx_eq) buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      buf_idx_q <= '0;
      buf_vld_q <= 1'b0;
      buf_dat_q <= '0;
      ack_q     <= 1'b0;
      ack_buf_q <= 1'b0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      buf_idx_q <= buf_idx_d;
      buf_vld_q <= buf_vld_d;
      buf_dat_q <= buf_dat_d;
      ack_q     <= ack_d;
      ack_buf_q <= ack_buf_d;
      if (hit_inc) hit_q <= sat_inc(hit_q);
      if (miss_inc) miss_q <= sat_inc(miss_q);
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = !ack_q    ? '0 :
                      ack_buf_q ? buf_dat_q : rdata;
  assign busy_o     = state_q != S_IDLE;
  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_mprj_bram_prefetch_ctrl.sv
// Directed bench for mprj_bram_prefetch_ctrl: latency, data,
// read-ahead hits, write invalidation, decode and reset behaviour.
module tb_mprj_bram_prefetch_ctrl;

  localparam int DLY = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        busy;
  logic [15:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int ack_edge = 0;

  mprj_bram_prefetch_ctrl #(.DELAY(DLY)) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .busy_o    (busy),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [31:0] rd);
    lat = 0;
    rd = '0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = i;
        rd = rdat;
        break;
      end
    end
    ack_edge = edge_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  int          lat, a0, acks;
  logic [31:0] rd;
  logic [31:0] wa [6];
  logic [31:0] wd [6];

  initial begin
    wa = '{32'h3800_0000, 32'h3800_0004, 32'h3800_0008,
           32'h3800_000C, 32'h3800_0FFC, 32'h3800_0020};
    wd = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002,
           32'h4444_0003, 32'hCAFE_03FF, 32'h5A5A_0020};

    #12;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    xfer(1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, lat, rd);
    chk("wr10_lat", lat, DLY + 1);
    chk("wr10_miss", miss_cnt, 0);
    idle(1);
    xfer(0, 32'h3800_0010, 0, 4'hF, lat, rd);
    chk("rd10_lat", lat, DLY + 1);
    chk("rd10_dat", rd, 32'hDEAD_BEEF);
    chk("rd10_miss", miss_cnt, 1);

    for (int i = 0; i < 6; i++) begin
      idle(1);
      xfer(1, wa[i], wd[i], 4'hF, lat, rd);
      chk("wr_init_lat", lat, DLY + 1);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      xfer(0, wa[i], 0, 4'hF, lat, rd);
      chk("seq_lat", lat, i == 0 ? DLY + 1 : 1);
      chk("seq_dat", rd, wd[i]);
      idle(12);
    end
    chk("seq_hit", hit_cnt, 3);
    chk("seq_miss", miss_cnt, 1);

    do_reset();
    xfer(0, wa[0], 0, 4'hF, lat, rd);
    a0 = ack_edge;
    idle(3);
    chk("pref_busy", busy, 1);
    xfer(0, wa[1], 0, 4'hF, lat, rd);
    chk("held_edge", ack_edge, a0 + DLY + 3);
    chk("held_dat", rd, wd[1]);
    chk("held_hit", hit_cnt, 1);
    chk("held_miss", miss_cnt, 1);

    do_reset();
    xfer(0, wa[0], 0, 4'hF, lat, rd);
    idle(12);
    xfer(1, wa[1], 32'h1234_5678, 4'hF, lat, rd);
    chk("inv_wr_lat", lat, DLY + 1);
    idle(1);
    xfer(0, wa[1], 0, 4'hF, lat, rd);
    chk("inv_rd_lat", lat, DLY + 1);
    chk("inv_rd_dat", rd, 32'h1234_5678);
    chk("inv_hit", hit_cnt, 0);
    chk("inv_miss", miss_cnt, 2);

    idle(1);
    xfer(1, wa[2], 32'hAAAA_55AA, 4'b0010, lat, rd);
    idle(1);
    xfer(0, wa[2], 0, 4'hF, lat, rd);
    chk("be_dat", rd, 32'h3333_5502);
    chk("be_miss", miss_cnt, 3);

    idle(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3900_0000;
    acks = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("undec_ack", acks, 0);
    chk("undec_hit", hit_cnt, 0);
    chk("undec_miss", miss_cnt, 3);

    idle(1);
    xfer(0, wa[4], 0, 4'hF, lat, rd);
    chk("top_lat", lat, DLY + 1);
    chk("top_dat", rd, wd[4]);
    idle(12);
    xfer(0, wa[0], 0, 4'hF, lat, rd);
    chk("wrap_lat", lat, 1);
    chk("wrap_dat", rd, wd[0]);
    chk("wrap_hit", hit_cnt, 1);
    chk("wrap_miss", miss_cnt, 4);

    idle(12);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = wa[5]; wdat = 32'hBAD0_0020;
    idle(5);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hit", hit_cnt, 0);
    chk("mid_rst_miss", miss_cnt, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    xfer(0, wa[5], 0, 4'hF, lat, rd);
    chk("no_commit_dat", rd, wd[5]);

    idle(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'h3800_0024; wdat = 32'h0BB0_0024;
    idle(3);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acks = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    chk("drop_ack", acks, 0);
    xfer(0, 32'h3800_0024, 0, 4'hF, lat, rd);
    chk("drop_commit_dat", rd, 32'h0BB0_0024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
